adc_spi_sampler: RTL and testbench



---
 rtl/adc_spi_pkg.sv | 47 ++++
 rtl/adc_spi_frame.sv | 99 +++++++++
 rtl/adc_spi_sampler.sv | 140 ++++++++++++++
 tb/tb_adc_spi_sampler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared state types, frame geometry and command bits for the SPI ADC sampler.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    UPDATE
  } adc_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_SETUP,
    F_SHIFT,
    F_HOLD
  } frame_phase_t;

  localparam logic [4:0] FRAME_BITS   = 5'd17;
  localparam logic [4:0] CMD_BITS     = 5'd4;
  localparam logic [4:0] NULL_BIT_IDX = 5'd4;
  localparam logic [4:0] DATA_MSB_IDX = NULL_BIT_IDX + 5'd1;
  localparam logic [4:0] LAST_BIT_IDX = FRAME_BITS - 5'd1;

  localparam logic CMD_START    = 1'b1;
  localparam logic CMD_SGL_DIFF = 1'b1;
  localparam logic CMD_MSBF     = 1'b1;

  localparam logic [11:0] FAULT_THRESHOLD = 12'h7D0;

  // MOSI level for SCLK period idx; zero once the command has been sent.
  function automatic logic cmd_bit(input logic [4:0] idx, input logic ch);
    logic b;
    b = 1'b0;
    if (idx < CMD_BITS) begin
      case (idx[1:0])
        2'd0:    b = CMD_START;
        2'd1:    b = CMD_SGL_DIFF;
        2'd2:    b = ch;
        default: b = CMD_MSBF;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// One MCP3202-style SPI frame: CS setup, 17 SCLK periods, CS hold.
// Captures the 12 data bits MSB first into data_out.
module adc_spi_frame
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int ADC_CH  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        adc_mosi,
  output logic        setup_done,
  output logic        shift_done,
  output logic        done,
  output logic [11:0] data_out
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic CH_BIT = ADC_CH[0];

  frame_phase_t     phase;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_idx;
  logic [11:0]      shreg;
  logic             tick;
  logic             data_bit;

  assign tick       = (div_cnt == '0);
  assign data_bit   = (bit_idx >= DATA_MSB_IDX) && (bit_idx <= LAST_BIT_IDX);
  assign setup_done = (phase == F_SETUP) && tick;
  assign shift_done = (phase == F_SHIFT) && tick && adc_sclk && (bit_idx == LAST_BIT_IDX);
  assign done       = (phase == F_HOLD) && tick;
  assign data_out   = shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= F_IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      adc_sclk <= 1'b0;
      adc_cs_n <= 1'b1;
      adc_mosi <= 1'b0;
    end else begin
      case (phase)
        F_IDLE: begin
          if (start) begin
            phase    <= F_SETUP;
            adc_cs_n <= 1'b0;
            div_cnt  <= DIV_LOAD;
          end
        end
        F_SETUP: begin
          if (tick) begin
            phase    <= F_SHIFT;
            div_cnt  <= DIV_LOAD;
            bit_idx  <= '0;
            adc_mosi <= cmd_bit(5'd0, CH_BIT);
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        F_SHIFT: begin
          if (!tick) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_LOAD;
            if (!adc_sclk) begin
              adc_sclk <= 1'b1;
              if (data_bit) shreg <= {shreg[10:0], adc_miso};
            end else begin
              // MOSI only moves on the falling edge, so it is stable while SCLK is high.
              adc_sclk <= 1'b0;
              if (bit_idx == LAST_BIT_IDX) begin
                phase    <= F_HOLD;
                adc_cs_n <= 1'b1;
                adc_mosi <= 1'b0;
              end else begin
                bit_idx  <= bit_idx + 5'd1;
                adc_mosi <= cmd_bit(bit_idx + 5'd1, CH_BIT);
              end
            end
          end
        end
        F_HOLD: begin
          if (tick) phase <= F_IDLE;
          else div_cnt <= div_cnt - DIV_W'(1);
        end
        default: phase <= F_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI ADC sampler averaging 2^AVG_LOG2 conversions into voltage.
// Define ADC_RANGE_CHECK_EN to add the sensor_fault output.
//
// state    | meaning
// IDLE     | sampling disabled, accumulator empty
// WAIT     | period timer running between frames
// CS_SETUP | CS low, before first SCLK
// SHIFT    | 17 SCLK periods of command/data
// CS_HOLD  | CS high guard time; sample accumulated on exit
// UPDATE   | averaged result presented with voltage_valid
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int AVG_LOG2      = 2,
  parameter int ADC_CH        = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        adc_mosi,
  output logic [11:0] voltage,
  output logic        voltage_valid,
  output logic        busy
`ifdef ADC_RANGE_CHECK_EN
  ,
  output logic        sensor_fault
`endif
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  adc_state_t       state;
  logic [TMR_W-1:0] tmr;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      sample;
  logic [11:0]      avg;
  logic             tmr_zero;
  logic             start;
  logic             setup_done;
  logic             shift_done;
  logic             frame_done;

  assign tmr_zero = (tmr == '0);
  assign start    = enable && ((state == IDLE) || ((state == WAIT) && tmr_zero));
  assign acc_sum  = acc + ACC_W'(sample);
  assign avg      = 12'(acc_sum >> AVG_LOG2);

  adc_spi_frame #(
    .CLK_DIV (CLK_DIV),
    .ADC_CH  (ADC_CH)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .adc_miso   (adc_miso),
    .adc_sclk   (adc_sclk),
    .adc_cs_n   (adc_cs_n),
    .adc_mosi   (adc_mosi),
    .setup_done (setup_done),
    .shift_done (shift_done),
    .done       (frame_done),
    .data_out   (sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tmr           <= '0;
      acc           <= '0;
      cnt           <= '0;
      voltage       <= '0;
      voltage_valid <= 1'b0;
      busy          <= 1'b0;
`ifdef ADC_RANGE_CHECK_EN
      sensor_fault  <= 1'b0;
`endif
    end else begin
      voltage_valid <= 1'b0;
      // Period timer is measured frame start to frame start.
      if (start) tmr <= TMR_LOAD;
      else if (!tmr_zero) tmr <= tmr - TMR_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            state <= CS_SETUP;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (tmr_zero) begin
            if (enable) begin
              state <= CS_SETUP;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              acc   <= '0;
              cnt   <= '0;
            end
          end
        end
        CS_SETUP: if (setup_done) state <= SHIFT;
        SHIFT:    if (shift_done) state <= CS_HOLD;
        CS_HOLD: begin
          if (frame_done) begin
            busy <= 1'b0;
            if (cnt == CNT_LAST) begin
              state         <= UPDATE;
              voltage       <= avg;
              voltage_valid <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
`ifdef ADC_RANGE_CHECK_EN
              sensor_fault  <= (avg <= FAULT_THRESHOLD);
`endif
            end else begin
              state <= WAIT;
              acc   <= acc_sum;
              cnt   <= cnt + CNT_W'(1);
            end
          end
        end
        UPDATE:  state <= WAIT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench for adc_spi_sampler: three instances (AVG_LOG2 0/2/4), each with an ADC model.
module tb_adc_spi_sampler;

  localparam int N = 3;

  typedef struct {
    int         inst;
    logic [11:0] v;
    logic        f;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] en  = '0;
  logic [N-1:0] sclk, cs_n, mosi, vv, busy;
`ifdef ADC_RANGE_CHECK_EN
  logic [N-1:0] fault;
`endif
  logic [11:0]  volt    [N];
  logic [11:0]  adc_val [N];
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  exp_t         expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic       miso_g = 1'b0;
    logic       sclk_q = 1'b0;
    logic       cs_q   = 1'b1;
    logic [3:0] cmd    = '0;
    int         rise = 0, last_rises = 0, falls = 0, fall_t = 0, gap = 0;

    adc_spi_sampler #(
      .CLK_DIV       (2),
      .SAMPLE_PERIOD (g == 0 ? 200 : 100),
      .AVG_LOG2      (g == 0 ? 0 : (g == 1 ? 2 : 4)),
      .ADC_CH        (0)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (en[g]),
      .adc_miso      (miso_g),
      .adc_sclk      (sclk[g]),
      .adc_cs_n      (cs_n[g]),
      .adc_mosi      (mosi[g]),
      .voltage       (volt[g]),
      .voltage_valid (vv[g]),
      .busy          (busy[g])
`ifdef ADC_RANGE_CHECK_EN
      ,
      .sensor_fault  (fault[g])
`endif
    );

    // ADC model: drives data bit after each SCLK fall from period 4 on, records MOSI and CS timing.
    always @(negedge clk) begin
      if (!cs_n[g] && cs_q) begin
        falls++;
        gap    = cyc - fall_t;
        fall_t = cyc;
        rise   = 0;
        cmd    = '0;
      end
      if (cs_n[g] && !cs_q) last_rises = rise;
      if (!cs_n[g]) begin
        if (sclk[g] && !sclk_q) begin
          rise++;
          if (rise <= 4) cmd = {cmd[2:0], mosi[g]};
        end else if (!sclk[g] && sclk_q && rise >= 5 && rise <= 16) begin
          miso_g = adc_val[g][4'(16 - rise)];
        end
      end
      cs_q   = cs_n[g];
      sclk_q = sclk[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int g, input logic [11:0] v);
    exp_t e;
    e.inst = g;
    e.v    = v;
    e.f    = (v <= 12'h7D0);
    expq.push_back(e);
  endtask

  task automatic wait_valid(input int g, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vv[g] && n < budget);
    if (!vv[g]) begin
      checks++;
      errors++;
      $display("FAIL timeout_valid inst %0d got none expected pulse within %0d cycles", g, budget);
    end
  endtask

  task automatic wait_cs(input int g, input logic want, input int budget);
    logic prev;
    bit   hit = 0;
    int   n = 0;
    prev = cs_n[g];
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit  = (cs_n[g] == want) && (prev != want);
      prev = cs_n[g];
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_cs inst %0d got no edge expected cs_n -> %0b within %0d cycles", g, want, budget);
    end
  endtask

  // Monitor: every valid pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int g = 0; g < N; g++) begin
        if (vv[g]) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid inst %0d got voltage %0h expected no pulse", g, volt[g]);
          end else begin
            e = expq.pop_front();
            chk("valid_inst", 32'(g), 32'(e.inst));
            chk("voltage", 32'(volt[g]), 32'(e.v));
`ifdef ADC_RANGE_CHECK_EN
            chk("sensor_fault", 32'(fault[g]), 32'(e.f));
`endif
          end
        end
      end
    end
  end

  initial begin
    int f0;
    for (int g = 0; g < N; g++) adc_val[g] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("rst_cs_n", 32'(cs_n[g]), 32'd1);
      chk("rst_sclk", 32'(sclk[g]), 32'd0);
      chk("rst_mosi", 32'(mosi[g]), 32'd0);
      chk("rst_voltage", 32'(volt[g]), 32'd0);
      chk("rst_valid", 32'(vv[g]), 32'd0);
      chk("rst_busy", 32'(busy[g]), 32'd0);
`ifdef ADC_RANGE_CHECK_EN
      chk("rst_fault", 32'(fault[g]), 32'd0);
`endif
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single conversion per output, frame shape and period.
    adc_val[0] = 12'hABC;
    push_exp(0, 12'hABC);
    en[0] = 1'b1;
    @(negedge clk);
    chk("cs_fall_latency", 32'(cs_n[0]), 32'd0);
    chk("busy_in_frame", 32'(busy[0]), 32'd1);
    wait_valid(0, 200);
    chk("sclk_rises", 32'(g_dut[0].last_rises), 32'd17);
    chk("mosi_cmd", 32'(g_dut[0].cmd), 32'hD);
    chk("busy_in_update", 32'(busy[0]), 32'd0);
    adc_val[0] = 12'h7D0;
    push_exp(0, 12'h7D0);
    wait_valid(0, 300);
    chk("cs_period", 32'(g_dut[0].gap), 32'd200);
    adc_val[0] = 12'h7D1;
    push_exp(0, 12'h7D1);
    wait_valid(0, 300);
    en[0] = 1'b0;
    repeat (250) @(negedge clk);
    chk("idle_busy", 32'(busy[0]), 32'd0);
    chk("idle_cs_n", 32'(cs_n[0]), 32'd1);

    // Average of four distinct samples.
    adc_val[1] = 12'h800;
    push_exp(1, 12'h803);
    en[1] = 1'b1;
    wait_cs(1, 1'b1, 150);
    adc_val[1] = 12'h802;
    wait_cs(1, 1'b1, 150);
    adc_val[1] = 12'h804;
    wait_cs(1, 1'b1, 150);
    adc_val[1] = 12'h807;
    wait_valid(1, 250);
    en[1] = 1'b0;
    repeat (150) @(negedge clk);

    // enable dropped mid-SHIFT of frame 2: no output, then a fresh set of four frames.
    adc_val[1] = 12'h400;
    en[1] = 1'b1;
    wait_cs(1, 1'b0, 10);
    wait_cs(1, 1'b0, 150);
    repeat (20) @(negedge clk);
    en[1] = 1'b0;
    f0 = g_dut[1].falls;
    repeat (250) @(negedge clk);
    chk("drop_no_new_frame", 32'(g_dut[1].falls - f0), 32'd0);
    chk("drop_busy", 32'(busy[1]), 32'd0);
    chk("drop_cs_n", 32'(cs_n[1]), 32'd1);
    chk("drop_voltage_held", 32'(volt[1]), 32'h803);
    adc_val[1] = 12'h100;
    push_exp(1, 12'h100);
    f0 = g_dut[1].falls;
    en[1] = 1'b1;
    wait_valid(1, 600);
    chk("reenable_frames", 32'(g_dut[1].falls - f0), 32'd4);
    en[1] = 1'b0;
    repeat (150) @(negedge clk);

    // Full-scale average over 16 frames.
    adc_val[2] = 12'hFFF;
    push_exp(2, 12'hFFF);
    en[2] = 1'b1;
    wait_valid(2, 1800);
    en[2] = 1'b0;
    repeat (150) @(negedge clk);

    // Asynchronous reset in the middle of SHIFT.
    adc_val[0] = 12'h555;
    en[0] = 1'b1;
    wait_cs(0, 1'b0, 10);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("mid_rst_sclk", 32'(sclk[0]), 32'd0);
    chk("mid_rst_voltage", 32'(volt[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_valid", 32'(vv[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_exp(0, 12'h555);
    wait_valid(0, 200);
    en[0] = 1'b0;

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
